// File: rtl/axi_cfg_pkg.sv
// Shared constants and helpers for the AXI-Lite configuration register block.
package axi_cfg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Ceiling log2; clogb2(1) = 0, clogb2(4) = 2, clogb2(5) = 3.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_cfg_register.sv
// AXI4-Lite slave exposing a flat bank of configuration words. Writes are
// assembled from independently captured AW and W beats and committed with a
// byte-strobe merge; reads return the word as it stood before the read edge.
module axi_cfg_register
  import axi_cfg_pkg::*;
#(
  parameter int CFG_DATA_WIDTH = 1024,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic [CFG_DATA_WIDTH-1:0]   cfg_data,
  output logic                        cfg_update,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);

  localparam int CFG_SIZE = CFG_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = clogb2(STRB_W);
  localparam int IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int SEL_W    = (CFG_SIZE > 1) ? clogb2(CFG_SIZE) : 1;
  localparam logic [IDX_W-1:0] CFG_SIZE_IDX = IDX_W'(CFG_SIZE);

  logic                      aw_full_q, aw_full_d;
  logic [IDX_W-1:0]          aw_idx_q, aw_idx_d;
  logic                      w_full_q, w_full_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      cfg_update_q, cfg_update_d;
  logic [CFG_DATA_WIDTH-1:0] cfg_q, cfg_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  logic                      aw_hs, w_hs, ar_hs, commit;
  logic                      wr_in_range, rd_in_range;
  logic [IDX_W-1:0]          rd_idx;
  logic [AXI_DATA_WIDTH-1:0] cfg_words [CFG_SIZE];

  // Byte offset within a word carries no meaning for this register bank.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

  // Holding registers refuse new beats while a response is still owed, which
  // keeps exactly one write in flight.
  assign s_axi_awready = ~aw_full_q & ~bvalid_q;
  assign s_axi_wready  = ~w_full_q & ~bvalid_q;
  assign s_axi_arready = ~rvalid_q;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = aw_full_q & w_full_q;

  assign wr_in_range = (aw_idx_q < CFG_SIZE_IDX);
  assign rd_idx      = s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_in_range = (rd_idx < CFG_SIZE_IDX);

  assign cfg_data    = cfg_q;
  assign cfg_update  = cfg_update_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

  // Per-byte next value: only the addressed word's strobed bytes take wdata.
  // An out-of-range index matches no word, so the bank is left untouched.
  for (genvar j = 0; j < CFG_SIZE; j++) begin : g_word
    assign cfg_words[j] = cfg_q[j*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    for (genvar b = 0; b < STRB_W; b++) begin : g_byte
      assign cfg_d[j*AXI_DATA_WIDTH + b*8 +: 8] =
        (commit && (aw_idx_q == IDX_W'(j)) && wstrb_q[b]) ? wdata_q[b*8 +: 8]
                                                          : cfg_q[j*AXI_DATA_WIDTH + b*8 +: 8];
    end
  end

  // Write path: capture AW/W independently, commit when both are held,
  // then hold the response until the master takes it.
  always_comb begin
    aw_full_d    = aw_full_q;
    aw_idx_d     = aw_idx_q;
    w_full_d     = w_full_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    cfg_update_d = commit;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axi_awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end
  end

  // Read path: sample the current (pre-commit) word on the AR handshake and
  // hold it until the master accepts.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? cfg_words[rd_idx[SEL_W-1:0]] : '0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset drops any half-assembled write and clears the bank.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_full_q    <= 1'b0;
      aw_idx_q     <= '0;
      w_full_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      cfg_update_q <= 1'b0;
      cfg_q        <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= 2'b00;
    end else begin
      aw_full_q    <= aw_full_d;
      aw_idx_q     <= aw_idx_d;
      w_full_q     <= w_full_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      cfg_update_q <= cfg_update_d;
      cfg_q        <= cfg_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

endmodule

// File: doc/axi_cfg_register.md
AXI_CFG_REGISTER -- requirements
Module: axi_cfg_register

Interface
REQ-001 Parameters SHALL be: CFG_DATA_WIDTH, 1024, total config bits; AXI_DATA_WIDTH, 32, bus word width; AXI_ADDR_WIDTH, 16, byte address width.
REQ-002 Derived values: CFG_SIZE = CFG_DATA_WIDTH/AXI_DATA_WIDTH words; ADDR_LSB = log2(AXI_DATA_WIDTH/8); word index = addr bits above ADDR_LSB.
REQ-003 Ports SHALL be, in order (clock and reset first):
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- cfg_data  out  CFG_DATA_WIDTH  configuration bits; word j = bits [j*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
- cfg_update  out  1  one-cycle pulse when a write commits
- s_axi_awaddr / awvalid / awready  in/in/out  AXI_ADDR_WIDTH/1/1  write address channel
- s_axi_wdata / wstrb / wvalid / wready  in/in/in/out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  write data channel
- s_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel
- s_axi_araddr / arvalid / arready  in/in/out  AXI_ADDR_WIDTH/1/1  read address channel
- s_axi_rdata / rresp / rvalid / rready  out/out/out/in  AXI_DATA_WIDTH/2/1/1  read data channel

Function
REQ-004 Address and data SHALL be captured independently into holding registers, each with a full flag (aw_full, w_full).
REQ-005 awready SHALL equal ~aw_full & ~bvalid; wready SHALL equal ~w_full & ~bvalid.
REQ-006 Handshake (valid & ready high at an edge) SHALL capture the payload and set the channel's full flag at that edge.
REQ-007 When aw_full & w_full at an edge, the write SHALL commit at that edge: both flags clear, bvalid sets, cfg_update pulses high for the following cycle.
REQ-008 Commit SHALL update only the bytes of the target word whose wstrb bit is 1; other bytes hold.
REQ-009 Word index >= CFG_SIZE SHALL leave all registers unchanged; bresp = 2'b10 (SLVERR), otherwise 2'b00 (OKAY).
REQ-010 bvalid SHALL hold until bvalid & bready at an edge, then clear; only one write SHALL be outstanding.
REQ-011 Latency: AW and W accepted at edge N give bvalid high from edge N+1; AW and W may arrive in either order or the same cycle.
REQ-012 arready SHALL equal ~rvalid.
REQ-013 AR handshake at edge N SHALL set rvalid and load rdata with the target word's value before edge N.
REQ-014 rdata SHALL be zero with rresp = 2'b10 for out-of-range reads; otherwise rresp = 2'b00.
REQ-015 rvalid and rdata SHALL hold until rvalid & rready at an edge, then rvalid clears.
REQ-016 A read and a commit to the same word at the same edge SHALL return the pre-commit value.
REQ-017 Read and write channels SHALL operate concurrently without mutual stalling.
REQ-018 cfg_data SHALL be driven directly from registers, with no combinational path from AXI inputs.

Reset
REQ-019 When aresetn is low at an edge, the following SHALL clear: all cfg words, aw_full, w_full, bvalid, rvalid, rdata, cfg_update; holding registers and bresp SHALL clear to zero.
REQ-020 During and after reset, awready, wready and arready SHALL read 1 (derived from the cleared flags).
REQ-021 A reset mid-transaction SHALL discard any captured but uncommitted write.

Structure
REQ-022 Package axi_cfg_pkg SHALL hold RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10 and the clogb2 function.
REQ-023 The block SHALL be a single flat module with no sub-module; the byte-enable update SHALL be a generate loop over words and bytes.

Verification
REQ-024 Single write: AW addr 0x0004 and W data 0xDEADBEEF, wstrb 0xF, same cycle -> bvalid next cycle, bresp 0, cfg_data[63:32] = 0xDEADBEEF, cfg_update pulses once.
REQ-025 Partial strobe: word 1 = 0xDEADBEEF, then write 0x11223344 with wstrb 0x5 -> word 1 = 0xDE22BE44.
REQ-026 Split order: W presented 3 cycles before AW (addr 0x0008, data 0x12345678) -> wready drops after capture, commit on the edge after AW capture, word 2 = 0x12345678.
REQ-027 Backpressure: bready held low 5 cycles -> bvalid, awready=0 and wready=0 all stable for those 5 cycles; a second write is accepted only after the B handshake.
REQ-028 Out of range (CFG_SIZE=32): write to 0x0080 -> bresp 2'b10, cfg_data unchanged; read of 0x0080 -> rdata 0, rresp 2'b10.
REQ-029 Reset mid-op: AW captured, W not yet presented, aresetn low for 1 cycle -> all outputs zero, ready signals 1, no commit occurs when W arrives alone afterwards.
